// File: rtl/dm.sv
// Shared DMI/DTM types: response payload, sticky op-status encoding and the
// response-capture FSM state.
package dm;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'd0,
        DTM_ERR     = 2'd2,
        DTM_BUSY    = 2'd3
    } dtm_op_status_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } cap_state_e;

endpackage

// File: rtl/dmi_shift_reg.sv
// Parametric capture/shift register; a capture in the same cycle as a shift
// takes priority. LSB is the serial output.
module dmi_shift_reg #(
    parameter int W = 41
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_capture,
    input  logic         i_shift,
    input  logic [W-1:0] i_cap_data,
    input  logic         i_tdi,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_q <= '0;
        else if (i_capture) r_q <= i_cap_data;
        else if (i_shift)   r_q <= {i_tdi, r_q[W-1:1]};
    end

    assign o_q = r_q;

endmodule

// File: rtl/dmi_jtag_resp_capture.sv
// JTAG-side DMI response consumer: one outstanding request, sticky op-status,
// Capture-DR/Shift-DR of {addr, data, op}. Optional DMI_RESP_TIMEOUT_EN adds a
// WAIT timeout that drains the late response.
module dmi_jtag_resp_capture
    import dm::*;
#(
    parameter int AbitsW        = 7,
    parameter int TimeoutCycles = 1024
) (
    input  logic              tck_i,
    input  logic              trst_ni,
    input  dm::dmi_resp_t     dmi_resp_i,
    input  logic              dmi_resp_valid_i,
    output logic              dmi_resp_ready_o,
    input  logic              req_sent_i,
    input  logic [AbitsW-1:0] req_addr_i,
    input  logic              dmi_select_i,
    input  logic              capture_dr_i,
    input  logic              shift_dr_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    input  logic              dmi_reset_i,
    output logic [1:0]        error_o,
    output logic              busy_o
);

    localparam int W = AbitsW + 34;

    cap_state_e        r_state;
    logic [AbitsW-1:0] r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_err;
    logic [W-1:0]      w_shift_q;
    logic [1:0]        w_op;
    logic              w_cap;
    logic              w_shift;
    logic              w_hs;
    logic              w_accept;
    logic              w_timeout;

`ifdef DMI_RESP_TIMEOUT_EN
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] r_cnt;
    logic            r_drain;

    assign dmi_resp_ready_o = (r_state == ST_WAIT) | r_drain;
    // A drained handshake belongs to the timed-out request, never the current one.
    assign w_accept  = w_hs & (r_state == ST_WAIT) & ~r_drain;
    assign w_timeout = (r_state == ST_WAIT) & ~w_accept & (r_cnt == CntW'(TimeoutCycles - 1));
`else
    assign dmi_resp_ready_o = (r_state == ST_WAIT);
    assign w_accept  = w_hs;
    assign w_timeout = 1'b0;
`endif

    assign w_hs    = dmi_resp_valid_i & dmi_resp_ready_o;
    assign w_cap   = capture_dr_i & dmi_select_i;
    assign w_shift = shift_dr_i & dmi_select_i;
    assign w_op    = (r_err != 2'd0)       ? r_err :
                     (r_state == ST_WAIT)  ? DTM_BUSY : DTM_SUCCESS;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= '0;
`ifdef DMI_RESP_TIMEOUT_EN
            r_cnt   <= '0;
            r_drain <= 1'b0;
`endif
        end else begin
`ifdef DMI_RESP_TIMEOUT_EN
            if (w_hs && r_drain) r_drain <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (req_sent_i) begin
                        r_addr  <= req_addr_i;
                        r_state <= ST_WAIT;
`ifdef DMI_RESP_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_data  <= dmi_resp_i.data;
                        r_state <= ST_IDLE;
                    end
`ifdef DMI_RESP_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= ST_IDLE;
                        r_drain <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase

            // First error sticks until dmireset, which beats any same-cycle set.
            if (dmi_reset_i)
                r_err <= DTM_SUCCESS;
            else if (r_err == 2'd0) begin
                if (w_cap && r_state == ST_WAIT)             r_err <= DTM_BUSY;
                else if (w_accept && dmi_resp_i.resp == 2'd2) r_err <= DTM_ERR;
                else if (w_accept && dmi_resp_i.resp == 2'd3) r_err <= DTM_BUSY;
                else if (w_timeout)                           r_err <= DTM_ERR;
            end
        end
    end

    dmi_shift_reg #(.W(W)) u_shift (
        .i_clk      (tck_i),
        .i_rst_n    (trst_ni),
        .i_capture  (w_cap),
        .i_shift    (w_shift),
        .i_cap_data ({r_addr, r_data, w_op}),
        .i_tdi      (tdi_i),
        .o_q        (w_shift_q)
    );

    assign tdo_o   = w_shift_q[0];
    assign error_o = r_err;
    assign busy_o  = (r_state == ST_WAIT);

    a_no_req_in_wait: assert property (@(posedge tck_i) disable iff (!trst_ni)
        !(req_sent_i && r_state == ST_WAIT));

endmodule
